// File: rtl/regfile_access_arbiter_if.sv
// Requester-side bundle of the register file arbiter: writer and reader handshakes plus read return.
// master = requesting datapath blocks, slave = arbiter.
interface regfile_access_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int N_WR       = 4,
  parameter int N_RD       = 4
);
  logic [N_WR-1:0]            wr_valid;
  logic [N_WR*ADDR_WIDTH-1:0] wr_addr;
  logic [N_WR*DATA_WIDTH-1:0] wr_data;
  logic [N_WR-1:0]            wr_ready;
  logic [N_RD-1:0]            rd_req;
  logic [N_RD*ADDR_WIDTH-1:0] rd_addr;
  logic [N_RD-1:0]            rd_grant;
  logic                       rd_valid;
  logic [N_RD-1:0]            rd_id;
  logic [DATA_WIDTH-1:0]      rd_data;

  modport master (
    output wr_valid, wr_addr, wr_data, rd_req, rd_addr,
    input  wr_ready, rd_grant, rd_valid, rd_id, rd_data
  );

  modport slave (
    input  wr_valid, wr_addr, wr_data, rd_req, rd_addr,
    output wr_ready, rd_grant, rd_valid, rd_id, rd_data
  );
endinterface

// File: rtl/regfile_access_arbiter.sv
// Round-robin sharing of register file write port A and read port B, plus a zero-fill clear sweep.
// Grants are same-cycle, read data 1 cycle later; requesters wait while not granted or while busy.
module regfile_access_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int N_WR       = 4,
  parameter int N_RD       = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  regfile_access_arbiter_if.slave bus,
  input  logic                  clear,
  output logic                  busy,
  output logic                  rf_we,
  output logic [ADDR_WIDTH-1:0] rf_addr_a,
  output logic [DATA_WIDTH-1:0] rf_data_a,
  output logic [ADDR_WIDTH-1:0] rf_addr_b,
  input  logic [DATA_WIDTH-1:0] rf_q_b
);
  localparam int WPW = (N_WR > 1) ? $clog2(N_WR) : 1;
  localparam int RPW = (N_RD > 1) ? $clog2(N_RD) : 1;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] clr_cnt;
  logic [WPW-1:0]        wr_ptr, wr_ptr_nxt;
  logic [RPW-1:0]        rd_ptr, rd_ptr_nxt;
  logic [N_WR-1:0]       wr_hi, wr_pick, wr_gnt;
  logic [N_RD-1:0]       rd_hi, rd_pick, rd_gnt;
  logic [ADDR_WIDTH-1:0] wr_addr_sel, rd_addr_sel;
  logic [DATA_WIDTH-1:0] wr_data_sel;
  logic                  arb_en;

  assign arb_en = reset && (state == IDLE);

  // Prefer the lowest requester at or above the pointer, else wrap to the lowest overall.
  always_comb begin
    wr_hi   = bus.wr_valid & ({N_WR{1'b1}} << wr_ptr);
    wr_pick = '0;
    if (wr_hi != '0) wr_pick = wr_hi & (~wr_hi + N_WR'(1));
    else             wr_pick = bus.wr_valid & (~bus.wr_valid + N_WR'(1));
    wr_gnt  = arb_en ? wr_pick : '0;

    rd_hi   = bus.rd_req & ({N_RD{1'b1}} << rd_ptr);
    rd_pick = '0;
    if (rd_hi != '0) rd_pick = rd_hi & (~rd_hi + N_RD'(1));
    else             rd_pick = bus.rd_req & (~bus.rd_req + N_RD'(1));
    rd_gnt  = arb_en ? rd_pick : '0;
  end

  always_comb begin
    wr_addr_sel = '0;
    wr_data_sel = '0;
    wr_ptr_nxt  = wr_ptr;
    for (int i = 0; i < N_WR; i++) begin
      if (wr_gnt[i]) begin
        wr_addr_sel = bus.wr_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        wr_data_sel = bus.wr_data[i*DATA_WIDTH +: DATA_WIDTH];
        wr_ptr_nxt  = WPW'((i + 1) % N_WR);
      end
    end
    rd_addr_sel = '0;
    rd_ptr_nxt  = rd_ptr;
    for (int j = 0; j < N_RD; j++) begin
      if (rd_gnt[j]) begin
        rd_addr_sel = bus.rd_addr[j*ADDR_WIDTH +: ADDR_WIDTH];
        rd_ptr_nxt  = RPW'((j + 1) % N_RD);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (clear) state_nxt = CLEAR;
      CLEAR:   if (clr_cnt == '1) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy         = 1'b0;
    rf_we        = 1'b0;
    rf_addr_a    = '0;
    rf_data_a    = '0;
    rf_addr_b    = rd_addr_sel;
    bus.wr_ready = wr_gnt;
    bus.rd_grant = rd_gnt;
    if (reset) begin
      if (state == CLEAR) begin
        busy      = 1'b1;
        rf_we     = 1'b1;
        rf_addr_a = clr_cnt;
      end else begin
        rf_we     = |wr_gnt;
        rf_addr_a = wr_addr_sel;
        rf_data_a = wr_data_sel;
      end
    end
  end

  // rd_id/rd_data hold their last return when no read was granted.
  always_ff @(posedge clk) begin
    if (!reset) begin
      clr_cnt      <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      bus.rd_valid <= 1'b0;
      bus.rd_id    <= '0;
      bus.rd_data  <= '0;
    end else begin
      clr_cnt      <= (state == CLEAR) ? clr_cnt + ADDR_WIDTH'(1) : '0;
      wr_ptr       <= wr_ptr_nxt;
      rd_ptr       <= rd_ptr_nxt;
      bus.rd_valid <= |rd_gnt;
      if (|rd_gnt) begin
        bus.rd_id   <= rd_gnt;
        bus.rd_data <= rf_q_b;
      end
    end
  end
endmodule

// File: tb/tb_regfile_access_arbiter.sv
// Bench for regfile_access_arbiter with a 16-entry register file model behind it.
// Read returns are matched against a queue of expected {id, data} filled as requests are driven.
module tb_regfile_access_arbiter;
  localparam int DW = 32;
  localparam int AW = 4;

  typedef struct {
    logic [3:0]   wv;
    logic [15:0]  wa;
    logic [127:0] wd;
    logic [3:0]   rq;
    logic [15:0]  ra;
    logic [3:0]   ewr;
    logic [3:0]   erd;
  } vec_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] data;
  } rd_exp_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          clear;
  logic          busy;
  logic          rf_we;
  logic [AW-1:0] rf_addr_a, rf_addr_b;
  logic [DW-1:0] rf_data_a, rf_q_b;
  logic [DW-1:0] mem     [16];
  logic [DW-1:0] exp_mem [16];
  rd_exp_t       sb_q [$];
  vec_t          tbl [14];
  int            n_checks = 0;
  int            n_fail   = 0;

  regfile_access_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .N_WR(4), .N_RD(4)) bus ();

  regfile_access_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .N_WR(4), .N_RD(4)) dut (
    .clk(clk), .reset(reset), .bus(bus), .clear(clear), .busy(busy),
    .rf_we(rf_we), .rf_addr_a(rf_addr_a), .rf_data_a(rf_data_a),
    .rf_addr_b(rf_addr_b), .rf_q_b(rf_q_b)
  );

  always #5 clk = ~clk;

  assign rf_q_b = (rf_we && rf_addr_a == rf_addr_b) ? rf_data_a : mem[rf_addr_b];

  always @(posedge clk) if (rf_we) mem[rf_addr_a] <= rf_data_a;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset === 1'b1 && bus.rd_valid === 1'b1) begin
      n_checks++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL rd_unexpected: got id %0h data %0h expected no return", bus.rd_id, bus.rd_data);
      end else begin
        rd_exp_t e;
        e = sb_q.pop_front();
        if (bus.rd_id !== e.id || bus.rd_data !== e.data) begin
          n_fail++;
          $display("FAIL rd_return: got id %0h data %0h expected id %0h data %0h",
                   bus.rd_id, bus.rd_data, e.id, e.data);
        end
      end
    end
  end

  function automatic vec_t mk(input logic [3:0] wv, input logic [15:0] wa, input logic [127:0] wd,
                              input logic [3:0] rq, input logic [15:0] ra,
                              input logic [3:0] ewr, input logic [3:0] erd);
    vec_t v;
    v.wv = wv; v.wa = wa; v.wd = wd; v.rq = rq; v.ra = ra; v.ewr = ewr; v.erd = erd;
    return v;
  endfunction

  task automatic apply(input vec_t v, input logic clr, input string name);
    logic [AW-1:0] waddr, raddr;
    logic [DW-1:0] wdat, rexp;
    logic          whit;
    rd_exp_t       e;
    @(posedge clk); #1;
    bus.wr_valid = v.wv; bus.wr_addr = v.wa; bus.wr_data = v.wd;
    bus.rd_req   = v.rq; bus.rd_addr = v.ra; clear = clr;
    whit = 1'b0; waddr = '0; wdat = '0; raddr = '0;
    for (int i = 0; i < 4; i++) begin
      if (v.ewr[i]) begin whit = 1'b1; waddr = v.wa[i*AW +: AW]; wdat = v.wd[i*DW +: DW]; end
      if (v.erd[i]) raddr = v.ra[i*AW +: AW];
    end
    #2;
    chk({name, ".wr_ready"}, 64'(bus.wr_ready), 64'(v.ewr));
    chk({name, ".rd_grant"}, 64'(bus.rd_grant), 64'(v.erd));
    chk({name, ".rf_we"},    64'(rf_we),        64'(whit));
    chk({name, ".addr_a"},   64'(rf_addr_a),    64'(waddr));
    chk({name, ".data_a"},   64'(rf_data_a),    64'(wdat));
    chk({name, ".addr_b"},   64'(rf_addr_b),    64'(raddr));
    chk({name, ".busy"},     64'(busy),         64'(0));
    if (v.erd != 4'b0) begin
      rexp = (whit && waddr == raddr) ? wdat : exp_mem[raddr];
      e.id = v.erd; e.data = rexp;
      sb_q.push_back(e);
    end
    if (whit) exp_mem[waddr] = wdat;
  endtask

  task automatic clear_cycles(input int n, input string name);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      clear = (k == 3);
      #2;
      chk($sformatf("%s.busy%0d", name, k),   64'(busy),         64'(1));
      chk($sformatf("%s.wrdy%0d", name, k),   64'(bus.wr_ready), 64'(0));
      chk($sformatf("%s.rgnt%0d", name, k),   64'(bus.rd_grant), 64'(0));
      chk($sformatf("%s.we%0d", name, k),     64'(rf_we),        64'(1));
      chk($sformatf("%s.addr%0d", name, k),   64'(rf_addr_a),    64'(k));
      chk($sformatf("%s.data%0d", name, k),   64'(rf_data_a),    64'(0));
    end
    clear = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin mem[i] = '0; exp_mem[i] = '0; end
    tbl[0]  = mk(4'b0000, 16'h0000, 128'h0, 4'b0000, 16'h0000, 4'b0000, 4'b0000);
    tbl[1]  = mk(4'b0101, 16'h0201, {32'h0, 32'h21, 32'h0, 32'h11}, 4'b0000, 16'h0, 4'b0001, 4'b0000);
    tbl[2]  = mk(4'b0101, 16'h0201, {32'h0, 32'h22, 32'h0, 32'h12}, 4'b0000, 16'h0, 4'b0100, 4'b0000);
    tbl[3]  = mk(4'b0101, 16'h0201, {32'h0, 32'h23, 32'h0, 32'h13}, 4'b0000, 16'h0, 4'b0001, 4'b0000);
    tbl[4]  = mk(4'b0101, 16'h0201, {32'h0, 32'h24, 32'h0, 32'h14}, 4'b0000, 16'h0, 4'b0100, 4'b0000);
    tbl[5]  = mk(4'b1000, 16'h3000, {32'h33, 96'h0}, 4'b1111, 16'h4321, 4'b1000, 4'b0001);
    tbl[6]  = mk(4'b0000, 16'h0000, 128'h0, 4'b1110, 16'h4321, 4'b0000, 4'b0010);
    tbl[7]  = mk(4'b0000, 16'h0000, 128'h0, 4'b1100, 16'h4321, 4'b0000, 4'b0100);
    tbl[8]  = mk(4'b0000, 16'h0000, 128'h0, 4'b1000, 16'h4321, 4'b0000, 4'b1000);
    tbl[9]  = mk(4'b0010, 16'h0050, {64'h0, 32'hDEADBEEF, 32'h0}, 4'b0010, 16'h0050, 4'b0010, 4'b0010);
    tbl[10] = mk(4'b1111, 16'h0600, {32'h0, 32'h66, 64'h0}, 4'b1111, 16'h0500, 4'b0100, 4'b0100);
    tbl[11] = mk(4'b0011, 16'h0087, {64'h0, 32'h88, 32'h77}, 4'b0101, 16'h0706, 4'b0001, 4'b0001);
    tbl[12] = mk(4'b0000, 16'h0000, 128'h0, 4'b0000, 16'h0000, 4'b0000, 4'b0000);
    tbl[13] = mk(4'b0011, 16'h0090, {64'h0, 32'h99, 32'h0}, 4'b0011, 16'h0090, 4'b0010, 4'b0010);

    // Reset with every input active: combinational outputs must stay quiet.
    reset = 1'b0; clear = 1'b1;
    bus.wr_valid = 4'hF; bus.wr_addr = 16'h4321; bus.wr_data = '1;
    bus.rd_req = 4'hF; bus.rd_addr = 16'h4321;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.busy", 64'(busy), 64'(0));
    chk("rst.rd_valid", 64'(bus.rd_valid), 64'(0));
    chk("rst.rd_id", 64'(bus.rd_id), 64'(0));
    chk("rst.rd_data", 64'(bus.rd_data), 64'(0));
    chk("rst.wr_ready", 64'(bus.wr_ready), 64'(0));
    chk("rst.rd_grant", 64'(bus.rd_grant), 64'(0));
    chk("rst.rf_we", 64'(rf_we), 64'(0));
    bus.wr_valid = '0; bus.rd_req = '0; clear = 1'b0;
    reset = 1'b1;

    for (int t = 0; t < 14; t++) apply(tbl[t], 1'b0, $sformatf("v%0d", t));

    // Clear requested while both ports are granted; those grants still complete.
    apply(mk(4'b1111, 16'h0B00, {32'h0, 32'hBB, 64'h0}, 4'b1111, 16'h0900, 4'b0100, 4'b0100), 1'b1, "clr_req");
    clear_cycles(16, "clr");
    for (int i = 0; i < 16; i++) exp_mem[i] = '0;
    for (int k = 0; k < 16; k++)
      apply(mk(4'b0000, 16'h0, 128'h0, 4'b0001, 16'(k), 4'b0000, 4'b0001), 1'b0, $sformatf("rb%0d", k));

    // Reset during the sweep aborts it and restarts both pointers at 0.
    apply(mk(4'b0000, 16'h0, 128'h0, 4'b0001, 16'h0, 4'b0000, 4'b0001), 1'b1, "clr2_req");
    clear_cycles(7, "clr2");
    @(posedge clk); #1;
    bus.wr_valid = 4'hF; bus.rd_req = 4'hF;
    reset = 1'b0;
    #2;
    chk("mid.busy", 64'(busy), 64'(0));
    chk("mid.rf_we", 64'(rf_we), 64'(0));
    chk("mid.wr_ready", 64'(bus.wr_ready), 64'(0));
    @(posedge clk); #1;
    chk("mid.rd_valid", 64'(bus.rd_valid), 64'(0));
    chk("mid.busy2", 64'(busy), 64'(0));
    bus.wr_valid = '0; bus.rd_req = '0;
    reset = 1'b1;
    apply(mk(4'b1111, 16'h000A, {96'h0, 32'hA5}, 4'b1111, 16'h000A, 4'b0001, 4'b0001), 1'b0, "post0");
    apply(mk(4'b1111, 16'h00C0, {64'h0, 32'hC1, 32'h0}, 4'b1111, 16'h00A0, 4'b0010, 4'b0010), 1'b0, "post1");

    @(posedge clk); #1;
    bus.wr_valid = '0; bus.rd_req = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("sb_drained", 64'(sb_q.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
